// File: rtl/dp3_bias_sequencer_if.sv
// +--------------------------------------------------------------------+
// | dp3_bias_sequencer_if : accumulator/ROM/result bus of the          |
// | layer-3 bias sequencer.                         Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

interface dp3_bias_sequencer_if #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 7,
  parameter int OUT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  in_acc;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [ADDR_W-1:0] out_ch;

  modport master (
    output in_valid, in_acc, rom_data, out_ready,
    input  in_ready, rom_addr, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_acc, rom_data, out_ready,
    output in_ready, rom_addr, out_valid, out_data, out_ch
  );
endinterface

`default_nettype wire

// File: rtl/dp3_bias_sequencer.sv
// +--------------------------------------------------------------------+
// | dp3_bias_sequencer : per-channel bias add, rescale and saturate    |
// | for one pixel of layer 3.                       Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module dp3_bias_sequencer #(
  parameter int NUM_CH     = 128,
  parameter int ADDR_W     = 7,
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 8,
  parameter int OUT_SHIFT  = 8,
  parameter int OUT_W      = 16
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire                 start_i,
  output logic                busy_o,
  output logic                done_o,
  dp3_bias_sequencer_if.slave bus
);

  localparam int c_SUM_W = ACC_W + 1;
  localparam logic [ADDR_W-1:0] c_LAST_CH = ADDR_W'(NUM_CH - 1);
  localparam logic signed [c_SUM_W-1:0] c_SAT_MAX =
    {{(c_SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [c_SUM_W-1:0] c_SAT_MIN =
    {{(c_SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ch_q, ch_d;
  logic               done_q, done_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_ch_q, out_ch_d;

  logic signed [c_SUM_W-1:0] w_acc_ext;
  logic signed [c_SUM_W-1:0] w_bias_ext;
  logic signed [c_SUM_W-1:0] w_sum;
  logic signed [c_SUM_W-1:0] w_scaled;
  logic [OUT_W-1:0]          w_clamped;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_out_fire;

  // Bias is placed at the accumulator's fixed point before the add.
  assign w_acc_ext  = {bus.in_acc[ACC_W-1], bus.in_acc};
  assign w_bias_ext = {{(c_SUM_W-8-BIAS_SHIFT){bus.rom_data[7]}},
                       bus.rom_data, {BIAS_SHIFT{1'b0}}};
  assign w_sum      = w_acc_ext + w_bias_ext;
  assign w_scaled   = w_sum >>> OUT_SHIFT;

  always_comb begin
    w_clamped = w_scaled[OUT_W-1:0];
    if (w_scaled > c_SAT_MAX) begin
      w_clamped = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_scaled < c_SAT_MIN) begin
      w_clamped = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  assign w_in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    // An accept in the same cycle as an output handshake reloads the register.
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = w_clamped;
      out_ch_d    = ch_q;
    end else if (w_out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          ch_d    = '0;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (ch_q == c_LAST_CH) begin
            state_d = S_DRAIN;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_out_fire) begin
          state_d = S_IDLE;
          ch_d    = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign bus.in_ready  = w_in_ready;
  assign bus.rom_addr  = ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_dp3_bias_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_dp3_bias_sequencer : randomized bench with a behavioural model  |
// | of the bias sequencer.                          Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dp3_bias_sequencer;

  localparam int NUM_CH = 128;
  localparam int ADDR_W = 7;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;

  typedef struct {
    int              ch;
    logic [OUT_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  wire  busy;
  wire  done;

  dp3_bias_sequencer_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  dp3_bias_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .ACC_W(ACC_W),
    .BIAS_SHIFT(8), .OUT_SHIFT(8), .OUT_W(OUT_W)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [NUM_CH];
  assign bus.rom_data = rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: exact sum, floor division by 2^8, then clamp to 16-bit signed.
  function automatic logic [OUT_W-1:0] ref_out(input logic signed [ACC_W-1:0] acc,
                                               input logic [7:0] b);
    longint s, d;
    int     bb;
    logic [63:0] r;
    bb = int'($signed(b));
    s  = longint'(acc) + longint'(bb) * 256;
    d  = (s >= 0) ? (s / 256) : -((-s + 255) / 256);
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    r = d;
    return r[OUT_W-1:0];
  endfunction

  bit   m_busy, m_done, m_outv;
  int   m_ch;
  exp_t q[$];
  int   cyc_cnt = 0, done_count = 0, start_cycle = 0, done_cycle = 0;
  logic [OUT_W-1:0] cap [NUM_CH];

  always @(negedge clk) begin
    bit   exp_rdy, acc, oh;
    int   rch;
    exp_t e;
    cyc_cnt++;
    rch     = m_busy ? ((m_ch < NUM_CH) ? m_ch : NUM_CH - 1) : 0;
    exp_rdy = m_busy && (m_ch < NUM_CH) && (!m_outv || bus.out_ready);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("out_valid", 32'(bus.out_valid), 32'(m_outv));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("rom_addr", 32'(bus.rom_addr), 32'(rch));
    if (m_outv && q.size() > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].data));
      chk("out_ch", 32'(bus.out_ch), 32'(q[0].ch));
    end
    if (done === 1'b1) begin
      done_count++;
      done_cycle = cyc_cnt;
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && !$isunknown(bus.out_ch))
      cap[bus.out_ch] = bus.out_data;

    m_done = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ch   = 0;
      m_outv = 1'b0;
      q.delete();
    end else begin
      acc = bus.in_valid && exp_rdy;
      oh  = m_outv && bus.out_ready;
      if (oh) void'(q.pop_front());
      if (acc) begin
        e.ch   = m_ch;
        e.data = ref_out(bus.in_acc, rom[m_ch]);
        q.push_back(e);
        m_ch++;
      end
      if (acc) m_outv = 1'b1;
      else if (oh) m_outv = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy      = 1'b1;
          m_ch        = 0;
          start_cycle = cyc_cnt;
        end
      end else if (m_ch == NUM_CH && !m_outv) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_ch   = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACC_W-1:0] rand_acc();
    case ($urandom % 4)
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      default: return ACC_W'($urandom);
    endcase
  endfunction

  // mode 0/1: directed streaming pixels; mode 2: random valid/ready with stray starts
  task automatic run_pixel(input int mode, input int budget);
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (done_count == d0 && n < budget) begin
      if (mode == 2) begin
        bus.in_valid  = ($urandom % 10) < 7;
        bus.out_ready = ($urandom % 10) < 6;
        start         = ($urandom % 10) == 0;
        bus.in_acc    = rand_acc();
      end else begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_acc    = rand_acc();
        if (mode == 0 && bus.rom_addr == 0)  bus.in_acc = 24'd0;
        if (mode == 0 && bus.rom_addr == 1)  bus.in_acc = 24'h7FFFFF;
        if (mode == 0 && bus.rom_addr == 63) bus.in_acc = 24'd256000;
        if (mode == 1 && bus.rom_addr == 0)  bus.in_acc = 24'h800000;
      end
      cyc();
      n++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("pixel_done_once", 32'(done_count - d0), 32'd1);
    cyc();
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < NUM_CH; i++) begin
      rom[i] = 8'($urandom);
      cap[i] = '0;
    end
    rom[0]  = 8'hA6;
    rom[1]  = 8'hC5;
    rom[63] = 8'h09;

    rst_n = 1'b0;
    start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_acc    = 24'h123456;
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);

    rst_n = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    chk("model_ch0_zero", 32'(ref_out(24'd0, 8'hA6)), 32'h0000FFA6);
    chk("model_pos_edge", 32'(ref_out(24'h7FFFFF, 8'hC5)), 32'h00007FC4);
    chk("model_neg_clamp", 32'(ref_out(24'h800000, 8'hA6)), 32'h00008000);
    chk("model_ch63", 32'(ref_out(24'd256000, 8'h09)), 32'd1009);

    run_pixel(0, 400);
    chk("stream_latency", 32'(done_cycle - start_cycle), 32'(NUM_CH + 2));
    chk("lit_ch0", 32'(cap[0]), 32'h0000FFA6);
    chk("lit_ch1", 32'(cap[1]), 32'h00007FC4);
    chk("lit_ch63", 32'(cap[63]), 32'd1009);

    run_pixel(1, 400);
    chk("lit_ch0_sat", 32'(cap[0]), 32'h00008000);

    for (int p = 0; p < 4; p++) run_pixel(2, 3000);

    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (bus.rom_addr != 7'd50 && n < 1000) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = ($urandom % 2) == 1;
      bus.in_acc    = rand_acc();
      cyc();
      n++;
    end
    chk("reach_ch50", 32'(bus.rom_addr), 32'd50);
    d0 = done_count;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (5) cyc();
    chk("midrst_no_done", 32'(done_count - d0), 32'd0);
    run_pixel(2, 3000);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
